// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of a single-port RAM: one access at a time, round-robin on ties.
// Optional port-1 address window check enabled by defining RAM_ARB_LOAD_GUARD_EN.
module ram_arbiter #(
  parameter int ADDR_W    = 9,
  parameter int DATA_W    = 32,
  parameter int RD_LAT    = 2,
  parameter int LOAD_BASE = 0,
  parameter int LOAD_TOP  = 511
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  output logic              busy
);

`ifdef RAM_ARB_LOAD_GUARD_EN
  localparam bit GUARD_EN = 1'b1;
`else
  localparam bit GUARD_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  state_t              state_q, state_d;
  logic                gnt_q, gnt_d;
  logic                last_q, last_d;
  logic                op_we_q, op_we_d;
  logic                rej_q, rej_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_data_q, ram_data_d;
  logic                ram_wren_q, ram_wren_d;
  logic [DATA_W-1:0]   p0_rdata_q, p0_rdata_d;
  logic [DATA_W-1:0]   p1_rdata_q, p1_rdata_d;

  logic sel;
  logic p1_oor;

  // On a tie the port that did not win last time is chosen.
  assign sel    = (p0_req && p1_req) ? ~last_q : p1_req;
  assign p1_oor = (int'(p1_addr) < LOAD_BASE) || (int'(p1_addr) > LOAD_TOP);

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_d     = last_q;
    op_we_d    = op_we_q;
    rej_d      = rej_q;
    cnt_d      = cnt_q;
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    ram_wren_d = 1'b0;
    p0_rdata_d = p0_rdata_q;
    p1_rdata_d = p1_rdata_q;
    case (state_q)
      IDLE: begin
        if (p0_req || p1_req) begin
          gnt_d   = sel;
          last_d  = sel;
          op_we_d = sel ? p1_we : p0_we;
          rej_d   = GUARD_EN && sel && p1_oor;
          // A rejected request leaves the RAM-facing registers untouched.
          if (!rej_d) begin
            ram_addr_d = sel ? p1_addr : p0_addr;
            ram_data_d = sel ? p1_wdata : p0_wdata;
            ram_wren_d = op_we_d;
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (rej_q || op_we_q) begin
          state_d = ACK;
        end else begin
          cnt_d   = 4'(RD_LAT - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          if (gnt_q) p1_rdata_d = ram_q;
          else       p0_rdata_d = ram_q;
          state_d = ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACK: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      gnt_q      <= 1'b0;
      last_q     <= 1'b1;
      op_we_q    <= 1'b0;
      rej_q      <= 1'b0;
      cnt_q      <= '0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
      ram_wren_q <= 1'b0;
      p0_rdata_q <= '0;
      p1_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      op_we_q    <= op_we_d;
      rej_q      <= rej_d;
      cnt_q      <= cnt_d;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
      ram_wren_q <= ram_wren_d;
      p0_rdata_q <= p0_rdata_d;
      p1_rdata_q <= p1_rdata_d;
    end
  end

  assign p0_ack   = (state_q == ACK) && !gnt_q;
  assign p1_ack   = (state_q == ACK) && gnt_q;
  assign p1_err   = (state_q == ACK) && gnt_q && rej_q;
  assign p0_rdata = p0_rdata_q;
  assign p1_rdata = p1_rdata_q;
  assign ram_addr = ram_addr_q;
  assign ram_data = ram_data_q;
  assign ram_wren = ram_wren_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural RAM of read latency RD_LAT.
module tb_ram_arbiter;
  localparam int RD_LAT = 2;
`ifdef RAM_ARB_LOAD_GUARD_EN
  localparam int LB    = 'h100;
  localparam bit GUARD = 1'b1;
`else
  localparam int LB    = 0;
  localparam bit GUARD = 1'b0;
`endif
  localparam logic [8:0] BB_ADDR = GUARD ? 9'h1AA : 9'h0AA;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        p0_req = 1'b0, p0_we = 1'b0;
  logic [8:0]  p0_addr = '0;
  logic [31:0] p0_wdata = '0;
  logic        p0_ack;
  logic [31:0] p0_rdata;
  logic        p1_req = 1'b0, p1_we = 1'b0;
  logic [8:0]  p1_addr = '0;
  logic [31:0] p1_wdata = '0;
  logic        p1_ack, p1_err;
  logic [31:0] p1_rdata;
  logic [8:0]  ram_addr;
  logic [31:0] ram_data;
  logic        ram_wren;
  logic [31:0] ram_q;
  logic        busy;

  int n_tests = 0, n_fail = 0;
  int wren_cnt = 0, both_cnt = 0, p1_ack_cnt = 0;
  logic [8:0] wren_addr = '0;
  logic last_err;

  ram_arbiter #(.ADDR_W(9), .DATA_W(32), .RD_LAT(RD_LAT), .LOAD_BASE(LB), .LOAD_TOP(511)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren),
    .ram_q(ram_q), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [512];
  logic [31:0] pipe [RD_LAT];
  initial for (int i = 0; i < 512; i++) mem[i] = '0;
  initial for (int i = 0; i < RD_LAT; i++) pipe[i] = '0;
  always @(posedge clk) begin
    if (ram_wren) mem[ram_addr] <= ram_data;
    pipe[0] <= mem[ram_addr];
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign ram_q = pipe[RD_LAT-1];

  always @(negedge clk) begin
    if (ram_wren) begin wren_cnt++; wren_addr = ram_addr; end
    if (p0_ack && p1_ack) both_cnt++;
    if (p1_ack) p1_ack_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Issues one request, returns during the ACK cycle with req dropped.
  task automatic access(input bit port, input bit we, input logic [8:0] addr,
                        input logic [31:0] wd, input int exp_lat,
                        input logic [31:0] exp_rd, input string tag);
    int cyc;
    bit got;
    if (port) begin p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wd; end
    else      begin p0_req = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wd; end
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      got = port ? p1_ack : p0_ack;
    end
    check_eq({tag, "_lat"}, cyc, exp_lat);
    if (got && !we) check_eq({tag, "_rdata"}, port ? p1_rdata : p0_rdata, exp_rd);
    last_err = p1_err;
    if (port) p1_req = 1'b0; else p0_req = 1'b0;
  endtask

  initial begin
    int w0, a0, n, cyc;
    int order [4];
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int w0, a0, n, cyc, first;
    int order [4];
    tick(3);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_acks", {p0_ack, p1_ack, p1_err}, 0);
    check_eq("rst_wren", ram_wren, 0);
    check_eq("rst_addr", ram_addr, 0);
    check_eq("rst_data", ram_data, 0);
    check_eq("rst_rdata", p0_rdata | p1_rdata, 0);
    reset = 1'b0;
    tick(2);

    w0 = wren_cnt;
    access(1'b0, 1'b1, 9'h010, 32'hDEADBEEF, 2, 0, "p0_wr");
    check_eq("p0_wr_pulses", wren_cnt - w0, 1);
    check_eq("p0_wr_addr", wren_addr, 9'h010);
    tick(2);

    w0 = wren_cnt;
    a0 = p1_ack_cnt;
    access(1'b0, 1'b0, 9'h010, 0, 4, 32'hDEADBEEF, "p0_rd");
    check_eq("p0_rd_nowren", wren_cnt - w0, 0);
    check_eq("p0_rd_p1quiet", p1_ack_cnt - a0, 0);
    tick(2);

    access(1'b1, 1'b1, BB_ADDR, 32'h12345678, 2, 0, "p1_wr");
    access(1'b0, 1'b0, BB_ADDR, 0, 5, 32'h12345678, "b2b_rd");
    tick(2);

    access(1'b0, 1'b1, 9'h050, 32'hCAFEF00D, 2, 0, "p0_wr50");
    tick(2);
    w0 = wren_cnt;
    access(1'b1, 1'b1, 9'h050, 32'h0BADBEEF, 2, 0, "p1_wr50");
    check_eq("p1_err", last_err, GUARD ? 1 : 0);
    check_eq("p1_wr50_pulses", wren_cnt - w0, GUARD ? 0 : 1);
    tick(2);
    access(1'b0, 1'b0, 9'h050, 0, 4, GUARD ? 32'hCAFEF00D : 32'h0BADBEEF, "rd50");
    tick(2);

    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    w0 = wren_cnt;
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 9'h020; p0_wdata = 32'h11111111;
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = 9'h120; p1_wdata = 32'h22222222;
    n = 0;
    cyc = 0;
    while (n < 4 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (p0_ack) begin order[n] = 0; n++; end
      else if (p1_ack) begin order[n] = 1; n++; end
    end
    p0_req = 1'b0;
    p1_req = 1'b0;
    check_eq("rr_count", n, 4);
    check_eq("rr_g0", order[0], 0);
    check_eq("rr_g1", order[1], 1);
    check_eq("rr_g2", order[2], 0);
    check_eq("rr_g3", order[3], 1);
    check_eq("rr_cycles", cyc, 11);
    check_eq("rr_pulses", wren_cnt - w0, 4);
    tick(2);

    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 9'h010;
    tick(2);
    check_eq("mid_busy", busy, 1);
    reset = 1'b1;
    p1_req = 1'b0;
    a0 = p1_ack_cnt;
    tick(1);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_ack", p1_ack, 0);
    check_eq("mid_rst_wren", ram_wren, 0);
    reset = 1'b0;
    tick(6);
    check_eq("mid_rst_noack", p1_ack_cnt - a0, 0);

    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 9'h010;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 9'h020;
    first = -1;
    cyc = 0;
    while (first < 0 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (p0_ack) first = 0;
      else if (p1_ack) first = 1;
    end
    p0_req = 1'b0;
    p1_req = 1'b0;
    check_eq("tie_first", first, 0);
    check_eq("tie_lat", cyc, 4);
    check_eq("tie_rdata", p0_rdata, 32'hDEADBEEF);
    tick(4);
    check_eq("never_both_ack", both_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-port RAM between two requesters: port 0 is the CPU memory path (MAR/MDR side, driven by the control unit) and port 1 is the program loader / debug port.
- Runs a small state machine that issues exactly one RAM access at a time, waits out the RAM read latency, and returns read data with a one-cycle ack pulse.
- Uses round-robin arbitration when both ports request in the same cycle.
- Sits between the datapath memory signals (address, write data, write enable, read data) and the RAM instance.

Parameters:
- ADDR_W, 9, RAM address width.
- DATA_W, 32, data word width; matches REG_SIZE.
- RD_LAT, 2, clk cycles from the RAM address being presented until ram_q is valid; legal range 1..15.
- LOAD_BASE, 0, lowest address port 1 may access (used only with the optional feature).
- LOAD_TOP, 511, highest address port 1 may access (used only with the optional feature).

Ports:
- clk, input, 1: system clock; all logic on posedge.
- reset, input, 1: synchronous, active-high reset.
- p0_req, input, 1: port 0 request; held until p0_ack.
- p0_we, input, 1: port 0 write (1) or read (0).
- p0_addr, input, ADDR_W: port 0 address.
- p0_wdata, input, DATA_W: port 0 write data.
- p0_ack, output, 1: one-cycle completion pulse for port 0.
- p0_rdata, output, DATA_W: port 0 read data, valid while p0_ack is high.
- p1_req / p1_we / p1_addr / p1_wdata / p1_ack / p1_rdata: same as port 0, for port 1.
- p1_err, output, 1: pulses with p1_ack when the request was rejected (optional feature only; otherwise tied 0).
- ram_addr, output, ADDR_W: registered RAM address.
- ram_data, output, DATA_W: registered RAM write data.
- ram_wren, output, 1: registered RAM write enable.
- ram_q, input, DATA_W: RAM read data.
- busy, output, 1: high in every state except IDLE.

Behaviour:
- Reset values: state=IDLE; every ack, p1_err, ram_wren and busy = 0; ram_addr, ram_data, p0_rdata, p1_rdata = 0; last_grant = 1, so port 0 wins the first tie.
- Reset asserted mid-access forces IDLE on the next edge. Any pending ack is dropped and ram_wren deasserts. Requesters must re-issue.
- IDLE:
  - If exactly one req is high, grant that port.
  - If both are high, grant the port that is not last_grant.
  - On grant, register ram_addr, ram_data and ram_wren (= that port's we), update last_grant, go to ISSUE.
  - If no req is high, stay in IDLE.
- ISSUE (1 cycle): the RAM sees the registered address and data; ram_wren is high only in this cycle. A write goes to ACK; a read loads the wait counter with RD_LAT-1 and goes to WAIT.
- WAIT: hold ram_addr and count down; at count 0 capture ram_q into the granted port's rdata and go to ACK.
- ACK (1 cycle): the granted port's ack = 1; rdata is held until that port's next read completes. Next state is IDLE.
- Handshake:
  - The requester samples ack at the clock edge that ends the ACK cycle. On that same edge it drops req or presents a new request.
  - IDLE then evaluates the updated req, so there is never a double issue.
  - req/we/addr/wdata are sampled only in IDLE; changes during an access are ignored.
- Latency, with req first seen in IDLE at cycle 0:
  - Write: ack in cycle 2.
  - Read: ack in cycle 2+RD_LAT.
  - Back-to-back: the next grant is made in the IDLE cycle following ACK, so throughput is one access per (3 + RD_LAT) cycles for reads and 3 cycles for writes.
- Fairness: with both ports continuously requesting, grants alternate 0,1,0,1…; neither port waits more than one access.
- ram_wren never goes high outside ISSUE. ack is never high for both ports in the same cycle.

Optional Feature:
- Macro: RAM_ARB_LOAD_GUARD_EN.
- Defined:
  - A port-1 request with p1_addr < LOAD_BASE or p1_addr > LOAD_TOP is granted normally but never reaches the RAM.
  - ISSUE keeps ram_wren = 0 and ram_addr unchanged, and the state machine goes straight to ACK.
  - p1_ack and p1_err pulse together; p1_rdata is unchanged.
  - Round-robin still counts the rejected request as a grant.
- Undefined: no range check is made and p1_err is constant 0.

Test Plan:
- Reset, then p0 write addr 0x010 data 0xDEADBEEF → ram_wren high for exactly 1 cycle with ram_addr=0x010; p0_ack in cycle 2.
- p0 read addr 0x010 with RD_LAT=2 → p0_ack in cycle 4 with p0_rdata=0xDEADBEEF; p1_ack stays 0.
- p0_req and p1_req both held high for 4 accesses from reset → grant order 0,1,0,1; exactly one ack per access, never both.
- Reset asserted during WAIT of a p1 read → next cycle busy=0, p1_ack never pulses, ram_wren=0; after reset is released a p0_req tie resolves to port 0.
- p1 writes 0x12345678 to 0x0AA; p0 reads 0x0AA back-to-back immediately after → p0_rdata=0x12345678 and the new grant is made in the first IDLE cycle after p1_ack.
- With RAM_ARB_LOAD_GUARD_EN, LOAD_BASE=0x100: p1 write to 0x050 → p1_ack and p1_err pulse in cycle 2, ram_wren stays 0, and a later p0 read of 0x050 returns the old value.
